// File: rtl/dlx_decode_queue.sv
// DLX decode stage: combinational instruction decode feeding a
// DEPTH-entry FIFO of decoded records toward execute.
module dlx_decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_alu_op,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_imm_sel,
  output logic             out_pc_alu,
  output logic [1:0]       out_pc_cmd,
  output logic [1:0]       out_pc_val,
  output logic             out_load,
  output logic             out_store,
  output logic             out_illegal,
  output logic [XLEN-1:0]  out_pc,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            imm_sel;
    logic            pc_alu;
    logic [1:0]      pc_cmd;
    logic [1:0]      pc_val;
    logic            load;
    logic            store;
    logic            illegal;
  } rec_t;

  rec_t            mem_q [DEPTH];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0] ill_q, ill_d;
  rec_t            dec, head;
  logic            push, pop, bad;
  logic [5:0]      op, fn;
  logic [XLEN-1:0] sx16, zx16, sx26;

  assign op   = in_instr[31:26];
  assign fn   = in_instr[5:0];
  assign sx16 = {{(XLEN-16){in_instr[15]}}, in_instr[15:0]};
  assign zx16 = {{(XLEN-16){1'b0}}, in_instr[15:0]};
  assign sx26 = {{(XLEN-26){in_instr[25]}}, in_instr[25:0]};

  // Decode the offered instruction into a full record
  always_comb begin
    dec     = '0;
    bad     = 1'b0;
    dec.pc  = in_pc;
    dec.rs1 = in_instr[25:21];
    dec.rs2 = in_instr[20:16];
    unique case (op)
      6'h00: begin
        dec.rd = in_instr[15:11];
        unique case (fn)
          6'h20: dec.alu = 4'd1;
          6'h22: dec.alu = 4'd2;
          6'h24: dec.alu = 4'd3;
          6'h25: dec.alu = 4'd4;
          6'h26: dec.alu = 4'd5;
          6'h04: dec.alu = 4'd6;
          6'h06: dec.alu = 4'd7;
          6'h07: dec.alu = 4'd14;
          6'h28: dec.alu = 4'd10;
          6'h29: dec.alu = 4'd13;
          6'h2a: dec.alu = 4'd12;
          6'h2c: dec.alu = 4'd11;
          default: bad = 1'b1;
        endcase
      end
      6'h08, 6'h0a, 6'h18, 6'h19, 6'h1a, 6'h1c, 6'h23, 6'h2b: begin
        dec.rd      = in_instr[20:16];
        dec.imm_sel = 1'b1;
        dec.imm     = sx16;
        unique case (op)
          6'h0a:   dec.alu = 4'd2;
          6'h18:   dec.alu = 4'd10;
          6'h19:   dec.alu = 4'd13;
          6'h1a:   dec.alu = 4'd12;
          6'h1c:   dec.alu = 4'd11;
          default: dec.alu = 4'd1;
        endcase
        dec.load  = (op == 6'h23);
        dec.store = (op == 6'h2b);
        if (op == 6'h2b) dec.rd = 5'd0;
      end
      6'h0c, 6'h0d, 6'h0e, 6'h14, 6'h16, 6'h17, 6'h0f: begin
        dec.rd      = in_instr[20:16];
        dec.imm_sel = 1'b1;
        dec.imm     = zx16;
        unique case (op)
          6'h0c:   dec.alu = 4'd3;
          6'h0d:   dec.alu = 4'd4;
          6'h0e:   dec.alu = 4'd5;
          6'h14:   dec.alu = 4'd6;
          6'h16:   dec.alu = 4'd7;
          6'h17:   dec.alu = 4'd14;
          default: dec.alu = 4'd0;
        endcase
      end
      6'h04, 6'h05: begin
        dec.pc_cmd = 2'b10;
        dec.imm    = sx16;
        dec.alu    = (op == 6'h04) ? 4'd8 : 4'd9;
        dec.rd     = (op == 6'h04) ? in_instr[20:16] : 5'd0;
      end
      6'h12, 6'h13: begin
        dec.pc_cmd = 2'b11;
        dec.pc_val = 2'b11;
        dec.imm    = zx16;
        dec.alu    = (op == 6'h13) ? 4'd15 : 4'd0;
        dec.rd     = (op == 6'h13) ? 5'd31 : 5'd0;
      end
      6'h02, 6'h03: begin
        dec.pc_cmd = 2'b10;
        dec.pc_val = 2'b01;
        dec.pc_alu = 1'b1;
        dec.rs1    = 5'd0;
        dec.rs2    = 5'd0;
        dec.imm    = sx26;
        dec.alu    = (op == 6'h03) ? 4'd15 : 4'd0;
        dec.rd     = (op == 6'h03) ? 5'd31 : 5'd0;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec         = '0;
      dec.pc      = in_pc;
      dec.illegal = 1'b1;
    end
  end

  assign in_ready  = (cnt_q < DEPTH_C);
  assign out_valid = (cnt_q != 3'd0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  // Next-state for pointers, occupancy and the illegal counter
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    ill_d = ill_q;
    if (push && dec.illegal && (ill_q != '1)) ill_d = ill_q + 1'b1;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = (wr_q == LAST) ? '0 : wr_q + 1'b1;
      if (pop)  rd_d = (rd_q == LAST) ? '0 : rd_q + 1'b1;
      if (push && !pop) cnt_d = cnt_q + 3'd1;
      if (pop && !push) cnt_d = cnt_q - 3'd1;
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ill_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ill_q <= ill_d;
    end
  end

  // Record storage; slot contents only matter while counted valid
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= dec;
  end

  assign head        = out_valid ? mem_q[rd_q] : '0;
  assign out_alu_op  = head.alu;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_rd      = head.rd;
  assign out_imm     = head.imm;
  assign out_imm_sel = head.imm_sel;
  assign out_pc_alu  = head.pc_alu;
  assign out_pc_cmd  = head.pc_cmd;
  assign out_pc_val  = head.pc_val;
  assign out_load    = head.load;
  assign out_store   = head.store;
  assign out_illegal = head.illegal;
  assign out_pc      = head.pc;
  assign illegal_cnt = ill_q;

endmodule

// File: tb/tb_dlx_decode_queue.sv
// Bench for dlx_decode_queue: vector table through a scoreboard,
// plus backpressure, flush, async reset and saturation sequences.
module tb_dlx_decode_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc32 = '0;
  logic [63:0] in_pc64 = '0;

  logic        a_in_ready, a_out_valid, a_imm_sel, a_pc_alu;
  logic        a_load, a_store, a_illegal;
  logic [3:0]  a_alu;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [31:0] a_imm, a_pc;
  logic [1:0]  a_pc_cmd, a_pc_val;
  logic [15:0] a_cnt;

  logic        b_in_ready, b_out_valid, b_imm_sel, b_pc_alu;
  logic        b_load, b_store, b_illegal;
  logic [3:0]  b_alu;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [63:0] b_imm, b_pc;
  logic [1:0]  b_pc_cmd, b_pc_val;
  logic [1:0]  b_cnt;

  dlx_decode_queue #(.XLEN(32), .DEPTH(2), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc32),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_alu_op(a_alu), .out_rs1(a_rs1), .out_rs2(a_rs2),
    .out_rd(a_rd), .out_imm(a_imm), .out_imm_sel(a_imm_sel),
    .out_pc_alu(a_pc_alu), .out_pc_cmd(a_pc_cmd),
    .out_pc_val(a_pc_val), .out_load(a_load),
    .out_store(a_store), .out_illegal(a_illegal),
    .out_pc(a_pc), .illegal_cnt(a_cnt)
  );

  dlx_decode_queue #(.XLEN(64), .DEPTH(2), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc64),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_alu_op(b_alu), .out_rs1(b_rs1), .out_rs2(b_rs2),
    .out_rd(b_rd), .out_imm(b_imm), .out_imm_sel(b_imm_sel),
    .out_pc_alu(b_pc_alu), .out_pc_cmd(b_pc_cmd),
    .out_pc_val(b_pc_val), .out_load(b_load),
    .out_store(b_store), .out_illegal(b_illegal),
    .out_pc(b_pc), .illegal_cnt(b_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  alu;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] imm;
    logic        imm_sel, pc_alu;
    logic [1:0]  pc_cmd, pc_val;
    logic        load, store, illegal;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [63:0] pc;
  } exp_t;

  vec_t        tbl [16];
  exp_t        sb [$];
  vec_t        cur_v;
  logic [63:0] cur_pc = '0;
  int          pcnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          m_cnt16 = 0;
  int          m_cnt2 = 0;
  bit          rand_rdy = 1'b0;

  function automatic vec_t mk(logic [31:0] i, int alu, int rs1,
      int rs2, int rd, logic [63:0] imm, bit isel, bit pcalu,
      int pcmd, int pval, bit ld, bit st, bit ill);
    vec_t v;
    v.instr = i; v.alu = 4'(alu);
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
    v.imm = imm; v.imm_sel = isel; v.pc_alu = pcalu;
    v.pc_cmd = 2'(pcmd); v.pc_val = 2'(pval);
    v.load = ld; v.store = st; v.illegal = ill;
    return v;
  endfunction

  function automatic logic [27:0] ctl(vec_t v);
    return {v.alu, v.rs1, v.rs2, v.rd, v.imm_sel, v.pc_alu,
            v.pc_cmd, v.pc_val, v.load, v.store, v.illegal};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: pop/compare on consumed head, push on accepted beat
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset) begin
      sb.delete();
      m_cnt16 = 0;
      m_cnt2 = 0;
    end else begin
      if (a_out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL pop-empty: got out_valid 1 expected 0");
        end else begin
          e = sb.pop_front();
          chk("rec ctl", 64'({a_alu, a_rs1, a_rs2, a_rd, a_imm_sel,
              a_pc_alu, a_pc_cmd, a_pc_val, a_load, a_store,
              a_illegal}), 64'(ctl(e.v)));
          chk("rec imm32", 64'(a_imm), 64'(e.v.imm[31:0]));
          chk("rec pc32", 64'(a_pc), 64'(e.pc[31:0]));
          chk("rec64 ctl", 64'({b_alu, b_rs1, b_rs2, b_rd, b_imm_sel,
              b_pc_alu, b_pc_cmd, b_pc_val, b_load, b_store,
              b_illegal}), 64'(ctl(e.v)));
          chk("rec imm64", b_imm, e.v.imm);
          chk("rec pc64", b_pc, e.pc);
        end
      end
      if (in_valid && a_in_ready && !flush) begin
        e.v = cur_v;
        e.pc = cur_pc;
        sb.push_back(e);
        if (cur_v.illegal) begin
          m_cnt16++;
          if (m_cnt2 < 3) m_cnt2++;
        end
      end
      if (flush) sb.delete();
    end
  end

  task automatic send(input vec_t v);
    bit acc;
    cur_v = v;
    pcnt++;
    cur_pc = {32'hC0DE0000, 32'(pcnt * 4)};
    in_instr = v.instr;
    in_pc32 = cur_pc[31:0];
    in_pc64 = cur_pc;
    in_valid = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = a_in_ready && !flush;
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
    if (!acc) begin
      n_tests++; n_fail++;
      $display("FAIL send timeout: got in_ready 0 expected 1");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 50 && sb.size() > 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("drain queue", 64'(sb.size()), 64'd0);
    chk("drain out_valid", 64'(a_out_valid), 64'd0);
  endtask

  initial begin
    tbl[0]  = mk(32'h00221820, 1, 1, 2, 3, 64'h0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(32'h2022FFFC, 1, 1, 2, 2, 64'hFFFF_FFFF_FFFF_FFFC,
                 1, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(32'h0FFFFFFF, 15, 0, 0, 31, 64'hFFFF_FFFF_FFFF_FFFF,
                 0, 1, 2, 1, 0, 0, 0);
    tbl[3]  = mk(32'hFC000000, 0, 0, 0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 1);
    tbl[4]  = mk(32'h0022183F, 0, 0, 0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 1);
    tbl[5]  = mk(32'h00C72822, 2, 6, 7, 5, 64'h0, 0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(32'h00221807, 14, 1, 2, 3, 64'h0, 0, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(32'h30648001, 3, 3, 4, 4, 64'h8001, 1, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(32'h8C480010, 1, 2, 8, 8, 64'h10, 1, 0, 0, 0, 1, 0, 0);
    tbl[9]  = mk(32'hAC49FFF0, 1, 2, 9, 0, 64'hFFFF_FFFF_FFFF_FFF0,
                 1, 0, 0, 0, 0, 1, 0);
    tbl[10] = mk(32'h1023FFF8, 8, 1, 3, 3, 64'hFFFF_FFFF_FFFF_FFF8,
                 0, 0, 2, 0, 0, 0, 0);
    tbl[11] = mk(32'h14230008, 9, 1, 3, 0, 64'h8, 0, 0, 2, 0, 0, 0, 0);
    tbl[12] = mk(32'h4C808000, 15, 4, 0, 31, 64'h8000,
                 0, 0, 3, 3, 0, 0, 0);
    tbl[13] = mk(32'h08000100, 0, 0, 0, 0, 64'h100, 0, 1, 2, 1, 0, 0, 0);
    tbl[14] = mk(32'h3C07ABCD, 0, 0, 7, 7, 64'hABCD, 1, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(32'h70228000, 11, 1, 2, 2, 64'hFFFF_FFFF_FFFF_8000,
                 1, 0, 0, 0, 0, 0, 0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 64'(a_out_valid), 64'd0);
    chk("rst in_ready", 64'(a_in_ready), 64'd1);
    chk("rst cnt", 64'(a_cnt), 64'd0);
    chk("rst alu", 64'(a_alu), 64'd0);
    chk("rst pc64", b_pc, 64'd0);
    chk("rst imm64", b_imm, 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // one-cycle latency, then fill to DEPTH and hold a third beat
    out_ready = 1'b0;
    send(tbl[0]);
    chk("latency valid", 64'(a_out_valid), 64'd1);
    chk("latency alu", 64'(a_alu), 64'd1);
    send(tbl[5]);
    chk("full in_ready", 64'(a_in_ready), 64'd0);
    fork
      send(tbl[2]);
      begin
        repeat (3) @(posedge clk);
        #2;
        chk("held in_ready", 64'(a_in_ready), 64'd0);
        chk("held head pc", 64'(a_pc), 64'(32'd4));
        out_ready = 1'b1;
      end
    join
    drain();

    // whole table with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 16; i++) send(tbl[i]);
    rand_rdy = 1'b0;
    drain();
    chk("table cnt16", 64'(a_cnt), 64'(m_cnt16));
    chk("table cnt2", 64'(b_cnt), 64'(m_cnt2));

    // flush with a beat offered: queue emptied, beat dropped
    out_ready = 1'b0;
    send(tbl[1]);
    send(tbl[6]);
    cur_v = tbl[3];
    in_instr = tbl[3].instr;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush out_valid", 64'(a_out_valid), 64'd0);
    chk("flush in_ready", 64'(a_in_ready), 64'd1);
    chk("flush cnt16", 64'(a_cnt), 64'(m_cnt16));
    out_ready = 1'b1;
    send(tbl[7]);
    drain();

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    send(tbl[0]);
    send(tbl[3]);
    #2 reset = 1'b1;
    #1;
    chk("areset out_valid", 64'(a_out_valid), 64'd0);
    chk("areset in_ready", 64'(a_in_ready), 64'd1);
    chk("areset cnt", 64'(a_cnt), 64'd0);
    chk("areset b valid", 64'(b_out_valid), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // counter saturation on the 2-bit instance
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(tbl[3 + (i % 2)]);
    drain();
    chk("sat cnt16", 64'(a_cnt), 64'(m_cnt16));
    chk("sat cnt2", 64'(b_cnt), 64'(m_cnt2));
    chk("sat cnt2 max", 64'(b_cnt), 64'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
